// File: rtl/mux4_rr_arbiter_if.sv
// Shared-channel bundle between four requesters and the round-robin 4:1 arbiter.
// master = requester side, slave = arbiter side.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       y;
  logic       busy;

  modport master (
    output req,
    output din,
    input  gnt,
    input  sel,
    input  y,
    input  busy
  );

  modport slave (
    input  req,
    input  din,
    output gnt,
    output sel,
    output y,
    output busy
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning a shared 4:1 mux; one owner at a time, bounded by
// MAX_HOLD cycles, with zero-gap handover to the next requester on release.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input logic             clk,
  input logic             rst_n,
  mux4_rr_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [7:0] hold_cnt;
  logic [3:0] gnt_q;
  logic [1:0] sel_q;
  logic       busy_q;

  logic [1:0] search_start;
  logic [1:0] winner;
  logic       release_now;

  // First asserted request at or after start, wrapping modulo 4.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  // While granted, search from the slot after the owner so the owner comes last.
  always_comb begin
    search_start = (state == GRANT) ? sel_q + 2'd1 : ptr;
    winner       = pick(bus.req, search_start);
    release_now  = !bus.req[sel_q] || (hold_cnt == HOLD_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      hold_cnt <= 8'd0;
      gnt_q    <= 4'b0000;
      sel_q    <= 2'd0;
      busy_q   <= 1'b0;
    end else if (state == IDLE) begin
      if (|bus.req) begin
        state    <= GRANT;
        gnt_q    <= 4'b0001 << winner;
        sel_q    <= winner;
        busy_q   <= 1'b1;
        hold_cnt <= 8'd0;
      end else begin
        gnt_q  <= 4'b0000;
        busy_q <= 1'b0;
      end
    end else begin
      if (release_now) begin
        ptr      <= sel_q + 2'd1;
        hold_cnt <= 8'd0;
        if (|bus.req) begin
          gnt_q <= 4'b0001 << winner;
          sel_q <= winner;
        end else begin
          state  <= IDLE;
          gnt_q  <= 4'b0000;
          busy_q <= 1'b0;
        end
      end else begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;
  assign bus.y    = busy_q & bus.din[sel_q];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: hand-derived vector table, directed corner sequences,
// and randomized traffic checked against an owner/cycle-count reference model.
module tb_mux4_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux4_rr_arbiter_if bus0();
  mux4_rr_arbiter_if bus1();

  mux4_rr_arbiter #(.MAX_HOLD(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mux4_rr_arbiter #(.MAX_HOLD(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the channel, for how many cycles, and where the
  // next search starts. Index 0 models MAX_HOLD=8, index 1 models MAX_HOLD=1.
  int m_owner[2];
  int m_cyc[2];
  int m_ptr[2];
  int m_sel[2];
  int lim[2];
  logic [3:0] cur_din;

  typedef struct {
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       y;
  } vec_t;
  vec_t tbl[14];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int first_req(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++)
      if (r[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = -1;
      m_cyc[i]   = 0;
      m_ptr[i]   = 0;
      m_sel[i]   = 0;
    end
  endtask

  task automatic step_models(input logic [3:0] r);
    for (int i = 0; i < 2; i++) begin
      if (m_owner[i] < 0) begin
        if (r != 4'b0000) begin
          m_owner[i] = first_req(r, m_ptr[i]);
          m_cyc[i]   = 1;
          m_sel[i]   = m_owner[i];
        end
      end else if (!r[m_owner[i]] || m_cyc[i] == lim[i]) begin
        m_ptr[i] = (m_owner[i] + 1) % 4;
        if (r != 4'b0000) begin
          m_owner[i] = first_req(r, m_ptr[i]);
          m_cyc[i]   = 1;
          m_sel[i]   = m_owner[i];
        end else begin
          m_owner[i] = -1;
        end
      end else begin
        m_cyc[i]++;
      end
    end
  endtask

  function automatic int exp_gnt(input int i);
    return (m_owner[i] >= 0) ? (1 << m_owner[i]) : 0;
  endfunction

  function automatic int exp_busy(input int i);
    return (m_owner[i] >= 0) ? 1 : 0;
  endfunction

  function automatic int exp_y(input int i);
    return (m_owner[i] >= 0) ? int'(cur_din[m_owner[i]]) : 0;
  endfunction

  task automatic check_models();
    check("model0_gnt",  int'(bus0.gnt),  exp_gnt(0));
    check("model0_sel",  int'(bus0.sel),  m_sel[0]);
    check("model0_busy", int'(bus0.busy), exp_busy(0));
    check("model0_y",    int'(bus0.y),    exp_y(0));
    check("model1_gnt",  int'(bus1.gnt),  exp_gnt(1));
    check("model1_sel",  int'(bus1.sel),  m_sel[1]);
    check("model1_busy", int'(bus1.busy), exp_busy(1));
    check("model1_y",    int'(bus1.y),    exp_y(1));
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] d);
    bus0.req = r;
    bus0.din = d;
    bus1.req = r;
    bus1.din = d;
    cur_din  = d;
  endtask

  task automatic advance();
    @(posedge clk);
    step_models(bus0.req);
    #1;
  endtask

  task automatic cycle(input logic [3:0] r, input logic [3:0] d);
    drive(r, d);
    #1;
    check_models();
    advance();
  endtask

  // Asserts reset without a clock edge, checks outputs, releases between edges.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_gnt",   int'(bus0.gnt),  0);
    check("rst_sel",   int'(bus0.sel),  0);
    check("rst_busy",  int'(bus0.busy), 0);
    check("rst_y",     int'(bus0.y),    0);
    check("rst1_gnt",  int'(bus1.gnt),  0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] d;
    lim[0] = 8;
    lim[1] = 1;
    drive(4'b0000, 4'b0000);

    // req, din, expected gnt, sel, busy, y observed during that cycle
    tbl[0]  = '{4'b0100, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[2]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[3]  = '{4'b0000, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[4]  = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0};
    tbl[5]  = '{4'b1111, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
    tbl[6]  = '{4'b0010, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
    tbl[7]  = '{4'b1011, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
    tbl[8]  = '{4'b1001, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
    tbl[9]  = '{4'b1001, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
    tbl[10] = '{4'b0001, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b1};
    tbl[11] = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[12] = '{4'b0000, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[13] = '{4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};

    apply_reset();

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].req, tbl[i].din);
      #1;
      check($sformatf("tbl%0d_gnt", i),  int'(bus0.gnt),  int'(tbl[i].gnt));
      check($sformatf("tbl%0d_sel", i),  int'(bus0.sel),  int'(tbl[i].sel));
      check($sformatf("tbl%0d_busy", i), int'(bus0.busy), int'(tbl[i].busy));
      check($sformatf("tbl%0d_y", i),    int'(bus0.y),    int'(tbl[i].y));
      check_models();
      advance();
    end

    // All four requesting from reset: 8-cycle slots on dut0, 1-cycle on dut1.
    apply_reset();
    for (int c = 0; c <= 40; c++) begin
      drive(4'b1111, 4'($urandom_range(0, 15)));
      #1;
      check_models();
      if (c > 0) begin
        check("rr8_sel",  int'(bus0.sel),  ((c - 1) / 8) % 4);
        check("rr8_busy", int'(bus0.busy), 1);
        check("rr1_sel",  int'(bus1.sel),  (c - 1) % 4);
      end
      advance();
    end

    // Lone requester past several timeouts keeps the grant without a gap.
    apply_reset();
    for (int c = 0; c <= 20; c++) begin
      drive(4'b0001, 4'($urandom_range(0, 15)));
      #1;
      check_models();
      if (c > 0) begin
        check("lone_gnt",  int'(bus0.gnt),  1);
        check("lone_busy", int'(bus0.busy), 1);
      end
      advance();
    end
    cycle(4'b0000, 4'b0000);

    // Data path: y follows din[2] only while requester 2 owns the channel.
    apply_reset();
    cycle(4'b0100, 4'b0000);
    for (int c = 0; c < 16; c++) begin
      d    = 4'($urandom_range(0, 15));
      d[2] = c[0];
      drive(4'b0100, d);
      #1;
      check("data_y", int'(bus0.y), int'(d[2]));
      check_models();
      advance();
    end
    cycle(4'b0000, 4'b1111);

    // Reset asserted between edges while requester 3 owns the channel.
    apply_reset();
    cycle(4'b1000, 4'b1000);
    drive(4'b1000, 4'b1000);
    #1;
    check("pre_rst_gnt", int'(bus0.gnt), 8);
    check("pre_rst_y",   int'(bus0.y),   1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt",  int'(bus0.gnt),  0);
    check("mid_rst_busy", int'(bus0.busy), 0);
    check("mid_rst_sel",  int'(bus0.sel),  0);
    check("mid_rst_y",    int'(bus0.y),    0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    drive(4'b1001, 4'b1111);
    rst_n = 1'b1;
    #1;
    check_models();
    advance();
    check("post_rst_gnt", int'(bus0.gnt), 1);
    check("post_rst_sel", int'(bus0.sel), 0);

    // Randomized traffic with sticky requests so timeouts and handovers occur.
    apply_reset();
    r = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      if (n % 97 == 50) apply_reset();
      cycle(r, 4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive cycles one requester may own the mux; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  request lines; req[i] high = requester i wants the shared 4:1 channel.
REQ-005 din  input  4  requester data; din[0]=A, din[1]=B, din[2]=C, din[3]=D.
REQ-006 gnt  output  4  one-hot grant, registered.
REQ-007 sel  output  2  mux select driven to the 4:1 mux, registered, equals index of granted requester.
REQ-008 y  output  1  shared channel output.
REQ-009 busy  output  1  high while a grant is active, registered.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (no owner) and GRANT (one owner).
REQ-011 The block SHALL keep a 2-bit rotating priority pointer ptr; search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-012 In IDLE with req != 0, the first asserted req in search order SHALL win; on the next edge gnt = one-hot(winner), sel = winner, busy = 1, hold counter = 0, state = GRANT (1-cycle request-to-grant latency).
REQ-013 In IDLE with req == 0, the block SHALL stay in IDLE with gnt = 0, busy = 0, sel unchanged.
REQ-014 In GRANT, y SHALL equal din[sel] combinationally; in IDLE, y SHALL be 0.
REQ-015 In GRANT, the hold counter SHALL increment each cycle the owner keeps req high.
REQ-016 Release SHALL occur at the edge where req[owner] is low, or where the hold counter equals MAX_HOLD-1 (owner held MAX_HOLD cycles).
REQ-017 On release, ptr SHALL become owner+1 (mod 4, 3 wraps to 0).
REQ-018 On release, if any req is high, the winner SHALL be chosen from owner+1 onward (owner searched last) and granted at the same edge with no IDLE gap; counter reset to 0.
REQ-019 On timeout release with only the owner requesting, the owner SHALL be re-granted with counter reset to 0.
REQ-020 On release with req == 0, state SHALL go to IDLE, gnt = 0, busy = 0.
REQ-021 Requests from non-owners during GRANT SHALL NOT affect gnt, sel or the counter until release.
REQ-022 gnt SHALL at all times be either 0 or exactly one-hot, and gnt SHALL equal busy ? one-hot(sel) : 0.
REQ-023 A requester dropping req and reasserting it in a later cycle SHALL be treated as a new request.
REQ-024 MAX_HOLD = 1 SHALL give strict per-cycle round-robin among continuously requesting inputs.

Reset
REQ-025 rst_n low SHALL immediately (no clock required) force state = IDLE, gnt = 0, sel = 0, busy = 0, ptr = 0, hold counter = 0, hence y = 0.
REQ-026 Reset asserted mid-grant SHALL abort the grant; after rst_n rises, arbitration SHALL restart from ptr = 0 on the first edge.

Verification
REQ-027 Single request: req=4'b0100, din=4'b0100, held 3 cycles then dropped -> one cycle later gnt=4'b0100, sel=2, busy=1, y=1; after drop gnt=0, busy=0, y=0, ptr=3.
REQ-028 Simultaneous requests from reset: req=4'b1111 held, MAX_HOLD=8 -> grants 0,1,2,3,0 each lasting exactly 8 cycles, no IDLE gap, sel tracking 0,1,2,3,0.
REQ-029 Voluntary release handover: owner 1 drops req while req[3] and req[0] high -> same edge gnt=4'b1000, sel=3; on 3's release, 0 granted (wrap-around).
REQ-030 Timeout with lone requester: req=4'b0001 held 20 cycles, MAX_HOLD=8 -> gnt stays 4'b0001 continuously, counter resets at cycles 8 and 16, busy never drops.
REQ-031 Data path: owner 2, din toggled 0/1 each cycle -> y follows din[2] same cycle; din[0],din[1],din[3] toggling have no effect on y.
REQ-032 Reset mid-grant: owner 3 active, rst_n pulsed low between edges -> gnt=0, busy=0, sel=0, y=0 immediately; after release with req=4'b1001 -> requester 0 granted first.
